mod_exp: RTL and testbench
==========================

# mod_exp

- Top-level modular exponentiation engine for the 4096-bit RSA datapath. Computes `C = M^E mod N` using word-serial Montgomery multiplication.
- Operands stream in and the result streams out as 64 × 64-bit words, least-significant word first.
- The host supplies three precomputed values: `R mod N`, `R² mod N` and `N'0 = -N⁻¹ mod 2^64`, with `R = 2^4096`. These come from the companion R/T and inverse blocks.

## Interface
- `DATA_WIDTH`, 64: word width; must be 64.
- `WORDS`, 64: words per operand; operand width = `DATA_WIDTH*WORDS` = 4096.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `m_buf` in 64: message word.
- `e_buf` in 64: exponent word.
- `n_buf` in 64: modulus word (odd, N > 1).
- `r_buf` in 64: `R mod N` word.
- `t_buf` in 64: `R² mod N` word.
- `nprime0` in 64: `-N⁻¹ mod 2^64`; sampled in LOAD_N.
- `startInput` in 1: arms loading.
- `startCompute` in 1: permits compute start and output phase.
- `getResult` in 1: high ends the load window.
- `exp_state` out 5: top FSM state code.
- `state` out 4: Montgomery-multiplier sub-state.
- `res_out` out 64: result word.

## Operation
- Top FSM encodings: INIT_STATE=0, LOAD_M_E=1, LOAD_N=2, WAIT_COMPUTE=3, CALC_M_BAR=4, GET_K_E=5, BIGLOOP=6, CALC_C_BAR_M_BAR=7, CALC_C_BAR_1=8, COMPLETE=9, OUTPUT_RESULT=10, TERMINAL=11. Codes 12–31 are unused and go to INIT_STATE.
- **INIT_STATE → LOAD_M_E** when `startInput`=1.
- **LOAD_M_E**: each cycle with `getResult`=0, all five 4096-bit registers (M, E, N, Rm, T) shift right by 64, and the current input word enters the top.
  - After K ≥ 64 shifts, the last 64 words presented hold, word 0 = first of those 64 at the LSB.
  - Earlier words are discarded.
  - A cycle with `getResult`=1 captures nothing and moves to LOAD_N.
- **LOAD_N** (1 cycle): latch `nprime0`; set C̄ = Rm → WAIT_COMPUTE.
- **WAIT_COMPUTE → CALC_M_BAR** when `startCompute`=1.
- **CALC_M_BAR**: M̄ = MonPro(M, T) → GET_K_E.
- **GET_K_E**: k = index of the most significant set bit of E.
  - E=0 → go straight to CALC_C_BAR_1.
  - Otherwise → BIGLOOP with i = k.
- **BIGLOOP**: C̄ = MonPro(C̄, C̄).
  - If E[i]=1 → CALC_C_BAR_M_BAR: C̄ = MonPro(C̄, M̄).
  - Then, if i=0 → CALC_C_BAR_1; else i−1 and repeat BIGLOOP.
- **CALC_C_BAR_1**: C = MonPro(C̄, 1) → COMPLETE.
- **COMPLETE** (1 cycle; advances when `startCompute`=1) → OUTPUT_RESULT.
- **OUTPUT_RESULT** streams C (see Timing) → TERMINAL.
- **TERMINAL**: holds until reset; `res_out` holds word 63.
- **MonPro(A,B)** = A·B·R⁻¹ mod N, computed word-serial CIOS:
  - One 64×64 multiply-accumulate per cycle.
  - q = (t0·nprime0) mod 2^64.
  - Carry chain is 4097+ bits wide.
  - Final conditional subtract: if result ≥ N, subtract N. Result is < N.
- `state` codes: 0 IDLE, 1 MUL, 2 RED, 3 SHIFT, 4 SUB, 5 DONE. It is 0 whenever no MonPro is active.
- **Inputs**: M ≥ N is accepted; the result is still M^E mod N provided M < R. Results for even N are undefined.

## Timing
- **Reset**: `exp_state`=0, `state`=0, `res_out`=0, and all operand/accumulator registers cleared. Reset at any point aborts in-flight work; the next cycle is INIT_STATE.
- **Inputs**: all sampled on the rising edge; `startInput`/`startCompute` are level-sensitive.
- **Output stream**: let c0 be the single cycle with `exp_state`=9.
  - c1: `exp_state`=10, `res_out`=0.
  - c2..c65: `res_out` = C word 0..63, one per cycle.
  - c66: `exp_state`=11.
- **MonPro latency**: fixed and ≤ 2·64·64 + 140 cycles, independent of data.
- **Total latency**: from `startCompute` to COMPLETE = (2 + k + 1 + popcount(E)) MonPro runs + ≤ 8 state-overhead cycles.
- **Monotonic states**: `exp_state` never revisits LOAD_* without reset.

## Configuration
- `MODEXP_EARLY_EXP_SKIP_EN`:
  - **Defined**: GET_K_E scans E for k, with a scan of ≤ 4096 cycles and ≥ 64 bits per cycle allowed.
  - **Undefined**: GET_K_E lasts 1 cycle and k = 4095. Leading zero bits then execute the squarings on C̄ = R mod N.
  - Results are identical either way; only latency differs.

## Test plan
- **Base case**: M=8, E=13, N=77 with matching R mod N, R² mod N, N'0, 64 words loaded then `getResult`=1 → output word0 = 50, words 1..63 = 0, then TERMINAL.
- **Zero exponent**: M=8, E=0, N=77 → result 1; BIGLOOP (6) never entered.
- **Final-subtract path**: M=76, E=2, N=77 → 1. Also M=0, E=5, N=77 → 0.
- **Load window**: 10 garbage words before the 64 valid words → result identical to the base case (50).
- **Reset mid-run**: assert `reset` during BIGLOOP → next cycle `exp_state`=0, `state`=0, `res_out`=0. A full rerun of the base case then returns 50.
- **Macro build**: both builds of the base case → 50; the build without the macro takes more cycles to reach COMPLETE.

Source files
------------

// File: rtl/mod_exp.sv
// mod_exp: word-serial Montgomery modular exponentiation engine, C = M^E mod N
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m_buf/e_buf/n_buf          message, exponent, modulus word (LS word first)
//   r_buf/t_buf                R mod N and R^2 mod N words, R = 2^(DATA_WIDTH*WORDS)
//   nprime0                    -N^-1 mod 2^DATA_WIDTH, latched in LOAD_N
//   startInput                 arms operand loading
//   startCompute               permits compute start and the output phase
//   getResult                  closes the load window
//   exp_state                  top FSM state code
//   state                      Montgomery multiplier sub-state
//   res_out                    result word stream
// Build option: MODEXP_EARLY_EXP_SKIP_EN scans E for its leading one so leading
// zero bits cost no squarings; without it the loop always starts at the top bit.
module mod_exp #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [DATA_WIDTH-1:0] nprime0,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    output logic [4:0]            exp_state,
    output logic [3:0]            state,
    output logic [DATA_WIDTH-1:0] res_out
);
    localparam int DW  = DATA_WIDTH;
    localparam int DW1 = DW + 1;
    localparam int DW2 = 2 * DW;
    localparam int OW  = DW * WORDS;
    localparam int TW  = OW + 2 * DW;
    localparam int IW  = $clog2(WORDS);
    localparam int JW  = $clog2(WORDS + 1);
    localparam int BW  = $clog2(OW);
    localparam logic [4:0] INIT_STATE       = 5'd0;
    localparam logic [4:0] LOAD_M_E         = 5'd1;
    localparam logic [4:0] LOAD_N           = 5'd2;
    localparam logic [4:0] WAIT_COMPUTE     = 5'd3;
    localparam logic [4:0] CALC_M_BAR       = 5'd4;
    localparam logic [4:0] GET_K_E          = 5'd5;
    localparam logic [4:0] BIGLOOP          = 5'd6;
    localparam logic [4:0] CALC_C_BAR_M_BAR = 5'd7;
    localparam logic [4:0] CALC_C_BAR_1     = 5'd8;
    localparam logic [4:0] COMPLETE         = 5'd9;
    localparam logic [4:0] OUTPUT_RESULT    = 5'd10;
    localparam logic [4:0] TERMINAL         = 5'd11;
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_MUL   = 4'd1;
    localparam logic [3:0] S_RED   = 4'd2;
    localparam logic [3:0] S_SHIFT = 4'd3;
    localparam logic [3:0] S_SUB   = 4'd4;
    localparam logic [3:0] S_DONE  = 4'd5;

    logic [OW-1:0]  m_reg, e_reg, n_reg, r_reg, t_reg, c_bar, m_bar;
    logic [DW-1:0]  np0, q, carry;
    // CIOS accumulator: WORDS words plus two carry words
    logic [TW-1:0]  t;
    logic [IW-1:0]  i_cnt;
    logic [JW-1:0]  j_cnt, o_cnt;
    logic [BW-1:0]  bit_idx;
    logic           mp_go, mp_done;
    logic [OW-1:0]  op_a, op_b;
    int             wi;
    logic [DW-1:0]  x, y, t_w, q_mul;
    logic [DW2-1:0] mac;
    logic [DW:0]    top;
    logic [OW:0]    t_red, t_sub;

    assign mp_go   = state == S_IDLE && (exp_state == CALC_M_BAR || exp_state == BIGLOOP ||
                     exp_state == CALC_C_BAR_M_BAR || exp_state == CALC_C_BAR_1);
    assign mp_done = state == S_DONE;
    assign op_a    = exp_state == CALC_M_BAR ? m_reg : c_bar;
    assign op_b    = exp_state == CALC_M_BAR ? t_reg :
                     exp_state == CALC_C_BAR_M_BAR ? m_bar :
                     exp_state == CALC_C_BAR_1 ? OW'(1) : c_bar;
    // In RED, j_cnt=0 is the cycle that forms q; words follow one index behind
    assign wi      = (state == S_RED && j_cnt != '0) ? int'(j_cnt) - 1 : int'(j_cnt);
    assign t_w     = t[wi*DW +: DW];
    assign x       = state == S_MUL ? op_a[wi*DW +: DW] : n_reg[wi*DW +: DW];
    assign y       = state == S_MUL ? op_b[int'(i_cnt)*DW +: DW] : q;
    assign mac     = DW2'(x) * DW2'(y) + DW2'(t_w) + DW2'(carry);
    assign top     = DW1'(t[WORDS*DW +: DW]) + DW1'(mac[DW2-1:DW]);
    assign q_mul   = t[DW-1:0] * np0;
    assign t_red   = t[OW:0];
    assign t_sub   = t_red - {1'b0, n_reg};

`ifdef MODEXP_EARLY_EXP_SKIP_EN
    localparam int LW = $clog2(DW);
    logic [IW-1:0] scan_w;
    logic [DW-1:0] e_word;
    assign e_word = e_reg[int'(scan_w)*DW +: DW];
    function automatic logic [LW-1:0] msb(input logic [DW-1:0] w);
        msb = '0;
        for (int b = 0; b < DW; b++) if (w[b]) msb = LW'(b);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= '0;
            q     <= '0;
            carry <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (mp_go) begin
                    t     <= '0;
                    carry <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    t[wi*DW +: DW] <= mac[DW-1:0];
                    carry          <= mac[DW2-1:DW];
                    if (j_cnt == JW'(WORDS - 1)) begin
                        t[WORDS*DW +: DW]     <= top[DW-1:0];
                        t[(WORDS+1)*DW +: DW] <= DW'(top[DW]);
                        carry                 <= '0;
                        j_cnt                 <= '0;
                        state                 <= S_RED;
                    end else j_cnt <= j_cnt + JW'(1);
                end
                S_RED: if (j_cnt == '0) begin
                    q     <= q_mul;
                    j_cnt <= JW'(1);
                end else begin
                    t[wi*DW +: DW] <= mac[DW-1:0];
                    carry          <= mac[DW2-1:DW];
                    if (j_cnt == JW'(WORDS)) begin
                        t[WORDS*DW +: DW]     <= top[DW-1:0];
                        t[(WORDS+1)*DW +: DW] <= t[(WORDS+1)*DW +: DW] + DW'(top[DW]);
                        j_cnt                 <= '0;
                        state                 <= S_SHIFT;
                    end else j_cnt <= j_cnt + JW'(1);
                end
                S_SHIFT: begin
                    t     <= t >> DW;
                    carry <= '0;
                    if (i_cnt == IW'(WORDS - 1)) state <= S_SUB;
                    else begin
                        i_cnt <= i_cnt + IW'(1);
                        state <= S_MUL;
                    end
                end
                S_SUB: begin
                    if (t_red >= {1'b0, n_reg}) t <= TW'(t_sub);
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_state <= INIT_STATE;
            m_reg     <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            r_reg     <= '0;
            t_reg     <= '0;
            c_bar     <= '0;
            m_bar     <= '0;
            np0       <= '0;
            bit_idx   <= '0;
            o_cnt     <= '0;
            res_out   <= '0;
`ifdef MODEXP_EARLY_EXP_SKIP_EN
            scan_w    <= '0;
`endif
        end else begin
            case (exp_state)
                INIT_STATE: if (startInput) exp_state <= LOAD_M_E;
                LOAD_M_E: if (getResult) exp_state <= LOAD_N;
                else begin
                    m_reg <= {m_buf, m_reg[OW-1:DW]};
                    e_reg <= {e_buf, e_reg[OW-1:DW]};
                    n_reg <= {n_buf, n_reg[OW-1:DW]};
                    r_reg <= {r_buf, r_reg[OW-1:DW]};
                    t_reg <= {t_buf, t_reg[OW-1:DW]};
                end
                LOAD_N: begin
                    np0       <= nprime0;
                    c_bar     <= r_reg;
`ifdef MODEXP_EARLY_EXP_SKIP_EN
                    scan_w    <= IW'(WORDS - 1);
`endif
                    exp_state <= WAIT_COMPUTE;
                end
                WAIT_COMPUTE: if (startCompute) exp_state <= CALC_M_BAR;
                CALC_M_BAR: if (mp_done) begin
                    m_bar     <= t[OW-1:0];
                    exp_state <= GET_K_E;
                end
                GET_K_E: if (e_reg == '0) exp_state <= CALC_C_BAR_1;
`ifdef MODEXP_EARLY_EXP_SKIP_EN
                else if (e_word != '0) begin
                    bit_idx   <= BW'(int'(scan_w) * DW + int'(msb(e_word)));
                    exp_state <= BIGLOOP;
                end else scan_w <= scan_w - IW'(1);
`else
                else begin
                    bit_idx   <= BW'(OW - 1);
                    exp_state <= BIGLOOP;
                end
`endif
                BIGLOOP: if (mp_done) begin
                    c_bar <= t[OW-1:0];
                    if (e_reg[bit_idx]) exp_state <= CALC_C_BAR_M_BAR;
                    else if (bit_idx == '0) exp_state <= CALC_C_BAR_1;
                    else bit_idx <= bit_idx - BW'(1);
                end
                CALC_C_BAR_M_BAR: if (mp_done) begin
                    c_bar <= t[OW-1:0];
                    if (bit_idx == '0) exp_state <= CALC_C_BAR_1;
                    else begin
                        bit_idx   <= bit_idx - BW'(1);
                        exp_state <= BIGLOOP;
                    end
                end
                CALC_C_BAR_1: if (mp_done) begin
                    c_bar     <= t[OW-1:0];
                    exp_state <= COMPLETE;
                end
                COMPLETE: if (startCompute) begin
                    res_out   <= '0;
                    o_cnt     <= '0;
                    exp_state <= OUTPUT_RESULT;
                end
                // One idle word slot first, then WORDS result words, LS first
                OUTPUT_RESULT: if (o_cnt == JW'(WORDS)) exp_state <= TERMINAL;
                else begin
                    res_out <= c_bar[DW-1:0];
                    c_bar   <= c_bar >> DW;
                    o_cnt   <= o_cnt + JW'(1);
                end
                TERMINAL: exp_state <= TERMINAL;
                default: exp_state <= INIT_STATE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: randomized self-checking bench for mod_exp against a plain-arithmetic model
module tb_mod_exp;
    localparam int DW  = 64;
    localparam int W   = 2;
    localparam int OW  = DW * W;
    localparam int OW2 = 2 * OW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] m_buf = '0, e_buf = '0, n_buf = '0, r_buf = '0, t_buf = '0, nprime0 = '0;
    logic          startInput = 1'b0, startCompute = 1'b0, getResult = 1'b0;
    logic [4:0]    exp_state;
    logic [3:0]    state;
    logic [DW-1:0] res_out;
    int            n_chk = 0, n_pass = 0;
    bit            stop_all = 1'b0;

    mod_exp #(.DATA_WIDTH(DW), .WORDS(W)) dut (
        .clk(clk), .reset(reset), .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf),
        .r_buf(r_buf), .t_buf(t_buf), .nprime0(nprime0), .startInput(startInput),
        .startCompute(startCompute), .getResult(getResult), .exp_state(exp_state),
        .state(state), .res_out(res_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [OW-1:0] mulmod(input logic [OW-1:0] a, b, n);
        logic [OW2-1:0] p;
        p = OW2'(a) * OW2'(b);
        return OW'(p % OW2'(n));
    endfunction

    function automatic logic [OW-1:0] ref_exp(input logic [OW-1:0] m, e, n);
        logic [OW-1:0] r, b;
        r = OW'(1) % n;
        b = m % n;
        for (int i = 0; i < OW; i++) begin
            if (e[i]) r = mulmod(r, b, n);
            b = mulmod(b, b, n);
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] r_mod(input logic [OW-1:0] n);
        logic [OW2-1:0] big;
        big = OW2'(1) << OW;
        return OW'(big % OW2'(n));
    endfunction

    function automatic logic [DW-1:0] np_of(input logic [DW-1:0] n0);
        logic [DW-1:0] v;
        v = 64'd1;
        for (int i = 0; i < 7; i++) v = v * (64'd2 - n0 * v);
        return 64'd0 - v;
    endfunction

    function automatic int msb_of(input logic [OW-1:0] e);
        int k;
        k = 0;
        for (int i = 0; i < OW; i++) if (e[i]) k = i;
        return k;
    endfunction

    task automatic run(input string tag, input logic [OW-1:0] m, e, n, input int garbage,
                       input bit abort, output logic [OW-1:0] got);
        logic [OW-1:0] rm, tt, expv;
        int lat, lo, hi, pc, big_cnt;
        bit saw_big;
        got = '0;
        rm = r_mod(n);
        tt = mulmod(rm, rm, n);
        expv = ref_exp(m, e, n);
        nprime0 = np_of(n[DW-1:0]);
        pc = $countones(e);
        reset = 1'b1; startInput = 1'b0; startCompute = 1'b0; getResult = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "/rst_exp_state"}, OW'(exp_state), OW'(0));
        check({tag, "/rst_res_out"}, OW'(res_out), OW'(0));
        reset = 1'b0;
        startInput = 1'b1;
        @(negedge clk);
        startInput = 1'b0;
        for (int g = 0; g < garbage + W; g++) begin
            if (g < garbage) begin
                m_buf = {$urandom, $urandom}; e_buf = {$urandom, $urandom};
                n_buf = {$urandom, $urandom}; r_buf = {$urandom, $urandom};
                t_buf = {$urandom, $urandom};
            end else begin
                m_buf = m[(g-garbage)*DW +: DW]; e_buf = e[(g-garbage)*DW +: DW];
                n_buf = n[(g-garbage)*DW +: DW]; r_buf = rm[(g-garbage)*DW +: DW];
                t_buf = tt[(g-garbage)*DW +: DW];
            end
            @(negedge clk);
        end
        getResult = 1'b1;
        @(negedge clk);
        getResult = 1'b0;
        @(negedge clk);
        check({tag, "/wait_state"}, OW'(exp_state), OW'(3));
        check({tag, "/idle_sub_state"}, OW'(state), OW'(0));
        hi = (e == '0 ? 2 : 3 + (OW - 1) + pc) * (2*W*W + 140) + 8;
        lo = (e == '0 ? 2 : 3 + msb_of(e) + pc) * 2*W*W;
        startCompute = 1'b1;
        lat = 0; big_cnt = 0; saw_big = 1'b0;
        while (exp_state != 5'd9 && lat <= hi + 10) begin
            @(negedge clk);
            lat++;
            if (exp_state == 5'd6) begin saw_big = 1'b1; big_cnt++; end
            if (abort && big_cnt == 3) begin
                reset = 1'b1;
                @(negedge clk);
                check({tag, "/abort_exp_state"}, OW'(exp_state), OW'(0));
                check({tag, "/abort_state"}, OW'(state), OW'(0));
                check({tag, "/abort_res_out"}, OW'(res_out), OW'(0));
                reset = 1'b0;
                startCompute = 1'b0;
                return;
            end
        end
        if (exp_state != 5'd9) begin
            check({tag, "/timeout"}, OW'(exp_state), OW'(9));
            stop_all = 1'b1;
            return;
        end
        check({tag, "/latency_in_window"}, OW'(lat >= lo && lat <= hi), OW'(1));
        check({tag, "/bigloop_entered"}, OW'(saw_big), OW'(e != '0));
        @(negedge clk);
        check({tag, "/c1_state"}, OW'(exp_state), OW'(10));
        check({tag, "/c1_res_out"}, OW'(res_out), OW'(0));
        for (int w = 0; w < W; w++) begin
            @(negedge clk);
            got[w*DW +: DW] = res_out;
        end
        check({tag, "/last_word_state"}, OW'(exp_state), OW'(10));
        @(negedge clk);
        check({tag, "/terminal_state"}, OW'(exp_state), OW'(11));
        check({tag, "/terminal_hold"}, OW'(res_out), OW'(expv[(W-1)*DW +: DW]));
        check({tag, "/result"}, got, expv);
        startCompute = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] got, m, e, n;
        run("base", OW'(8), OW'(13), OW'(77), 0, 1'b0, got);
        check("base_is_50", got, OW'(50));
        if (!stop_all) run("zero_exp", OW'(8), OW'(0), OW'(77), 0, 1'b0, got);
        if (!stop_all) check("zero_exp_is_1", got, OW'(1));
        if (!stop_all) run("sub_path", OW'(76), OW'(2), OW'(77), 0, 1'b0, got);
        if (!stop_all) check("sub_path_is_1", got, OW'(1));
        if (!stop_all) run("zero_msg", OW'(0), OW'(5), OW'(77), 0, 1'b0, got);
        if (!stop_all) check("zero_msg_is_0", got, OW'(0));
        if (!stop_all) run("load_window", OW'(8), OW'(13), OW'(77), 10, 1'b0, got);
        if (!stop_all) check("load_window_is_50", got, OW'(50));
        if (!stop_all) run("abort", OW'(8), OW'(13), OW'(77), 0, 1'b1, got);
        if (!stop_all) run("rerun", OW'(8), OW'(13), OW'(77), 0, 1'b0, got);
        if (!stop_all) check("rerun_is_50", got, OW'(50));
        for (int r = 0; r < 5 && !stop_all; r++) begin
            n = {$urandom, $urandom, $urandom, $urandom};
            if (r == 4) n = OW'($urandom_range(3, 65535));
            n[0] = 1'b1;
            if (r == 1) n[OW-1] = 1'b1;
            m = {$urandom, $urandom, $urandom, $urandom};
            e = {$urandom, $urandom, $urandom, $urandom};
            if (r == 2) e = OW'($urandom_range(1, 255));
            if (r == 3) e = OW'(1) << (OW - 1);
            run($sformatf("rand%0d", r), m, e, n, r, 1'b0, got);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
